// File: rtl/pipeline_mem_if.sv
// Bus between the execute stage and the memory stage of the MIPS pipeline.
// It carries the EX-stage results into the memory stage and the forwarding,
// write-back and interrupt outputs back out of it.
// master: the execute side, which drives the EX_* fields.
// slave:  the memory stage itself.
interface pipeline_mem_if;
    // Execute-stage results presented to the EX/MEM register
    logic        EX_Flush;
    logic [31:0] EX_ALUOut;
    logic [31:0] EX_StoreData;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        EX_RegWrite;
    logic [1:0]  EX_MemToReg;
    logic [4:0]  EX_Rd;
    logic [31:0] EX_PC4;

    // Forwarding, write-back and interrupt outputs
    logic [31:0] EXMEMdata;
    logic [4:0]  MEM_Rd;
    logic        MEM_RegWrite;
    logic [31:0] MEMWBdata;
    logic [4:0]  WB_Rd;
    logic        WB_RegWrite;
    logic        IRQ;

    modport master (
        output EX_Flush, EX_ALUOut, EX_StoreData, EX_MemRead, EX_MemWrite,
        output EX_RegWrite, EX_MemToReg, EX_Rd, EX_PC4,
        input  EXMEMdata, MEM_Rd, MEM_RegWrite, MEMWBdata, WB_Rd, WB_RegWrite, IRQ
    );

    modport slave (
        input  EX_Flush, EX_ALUOut, EX_StoreData, EX_MemRead, EX_MemWrite,
        input  EX_RegWrite, EX_MemToReg, EX_Rd, EX_PC4,
        output EXMEMdata, MEM_Rd, MEM_RegWrite, MEMWBdata, WB_Rd, WB_RegWrite, IRQ
    );
endinterface

// File: rtl/pipeline_mem.sv
// Memory stage of the five-stage MIPS pipeline.
// Holds the EX/MEM register, a word-addressed data RAM (async read, sync
// write), an optional memory-mapped timer, and the MEM/WB register.
// Optional feature macro: MEM_TIMER_EN. When it is defined, the timer
// (TH reload, TL up-counter, TCON {status, irq_en, enable}) is built at
// TIMER_BASE and drives IRQ. Otherwise the timer region reads 0, its writes
// are dropped and IRQ is tied low.
module pipeline_mem #(
    parameter int unsigned RAM_DEPTH  = 256,
    parameter logic [31:0] TIMER_BASE = 32'h4000_0000
) (
    input logic           clk,
    input logic           reset,
    pipeline_mem_if.slave bus
);

    localparam int unsigned IdxW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    // EX/MEM register
    logic [31:0] mem_alu_out_q;
    logic [31:0] mem_store_data_q;
    logic [31:0] mem_pc4_q;
    logic        mem_mem_read_q;
    logic        mem_mem_write_q;
    logic        mem_reg_write_q;
    logic [1:0]  mem_mem_to_reg_q;
    logic [4:0]  mem_rd_q;

    // MEM/WB register
    logic [31:0] wb_data_q;
    logic [31:0] wb_data_d;
    logic [4:0]  wb_rd_q;
    logic        wb_reg_write_q;

    // Address decode and read data
    logic [29:0]     word_addr;
    logic            ram_hit;
    logic [IdxW-1:0] ram_idx;
    logic [31:0]     ram_rdata;
    logic            timer_hit;
    logic [31:0]     timer_rdata;
    logic [31:0]     load_data;

    logic [31:0] ram_q [RAM_DEPTH];

    // Latch EX results every cycle; a flush turns the control bits into a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_alu_out_q    <= '0;
            mem_store_data_q <= '0;
            mem_pc4_q        <= '0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 2'b00;
            mem_rd_q         <= '0;
        end else begin
            mem_alu_out_q    <= bus.EX_ALUOut;
            mem_store_data_q <= bus.EX_StoreData;
            mem_pc4_q        <= bus.EX_PC4;
            mem_mem_read_q   <= bus.EX_MemRead & ~bus.EX_Flush;
            mem_mem_write_q  <= bus.EX_MemWrite & ~bus.EX_Flush;
            mem_reg_write_q  <= bus.EX_RegWrite & ~bus.EX_Flush;
            mem_mem_to_reg_q <= bus.EX_MemToReg;
            mem_rd_q         <= bus.EX_Rd;
        end
    end

    // Byte-offset bits are ignored: word accesses only
    assign word_addr = mem_alu_out_q[31:2];
    assign ram_hit   = ({2'b00, word_addr} < RAM_DEPTH);
    assign ram_idx   = word_addr[IdxW-1:0];
    assign ram_rdata = ram_q[ram_idx];

    // RAM write at the edge ending the MEM cycle. No reset term is needed:
    // an asserted reset has already cleared mem_mem_write_q asynchronously.
    always_ff @(posedge clk) begin
        if (mem_mem_write_q && ram_hit) begin
            ram_q[ram_idx] <= mem_store_data_q;
        end
    end

`ifdef MEM_TIMER_EN
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [1:0]  timer_off;
    logic        timer_wr;

    assign timer_off = mem_alu_out_q[3:2];
    assign timer_hit = (mem_alu_out_q[31:4] == TIMER_BASE[31:4]) && (timer_off != 2'b11);
    assign timer_wr  = mem_mem_write_q && timer_hit;

    // Register read mux; TCON upper bits read as zero
    always_comb begin
        timer_rdata = '0;
        case (timer_off)
            2'b00:   timer_rdata = th_q;
            2'b01:   timer_rdata = tl_q;
            2'b10:   timer_rdata = {29'b0, tcon_q};
            default: timer_rdata = '0;
        endcase
    end

    // Counter step first, then a CPU write overrides it in the same cycle
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d      = th_q;
                tcon_d[2] = tcon_q[2] | tcon_q[1];
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        if (timer_wr) begin
            case (timer_off)
                2'b00:   th_d   = mem_store_data_q;
                2'b01:   tl_d   = mem_store_data_q;
                2'b10:   tcon_d = mem_store_data_q[2:0];
                default: ;
            endcase
        end
    end

    // Timer state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign bus.IRQ = tcon_q[2];
`else
    logic unused_timer_base;

    assign timer_hit         = 1'b0;
    assign timer_rdata       = '0;
    assign bus.IRQ           = 1'b0;
    assign unused_timer_base = ^TIMER_BASE;
`endif

    // Load data: RAM, then timer, else unmapped reads as zero
    always_comb begin
        load_data = '0;
        if (ram_hit) begin
            load_data = ram_rdata;
        end else if (timer_hit) begin
            load_data = timer_rdata;
        end
    end

    // Write-back select
    always_comb begin
        wb_data_d = '0;
        case (mem_mem_to_reg_q)
            2'd0:    wb_data_d = mem_alu_out_q;
            2'd1:    wb_data_d = load_data;
            2'd2:    wb_data_d = mem_pc4_q;
            default: wb_data_d = '0;
        endcase
    end

    // MEM/WB register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
        end else begin
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= mem_rd_q;
            wb_reg_write_q <= mem_reg_write_q;
        end
    end

    assign bus.EXMEMdata    = mem_alu_out_q;
    assign bus.MEM_Rd       = mem_rd_q;
    assign bus.MEM_RegWrite = mem_reg_write_q;
    assign bus.MEMWBdata    = wb_data_q;
    assign bus.WB_Rd        = wb_rd_q;
    assign bus.WB_RegWrite  = wb_reg_write_q;

    // MemRead has no effect on a word-only RAM with async read
    logic unused_bits;
    assign unused_bits = ^{mem_alu_out_q[1:0], mem_mem_read_q};

endmodule

// File: tb/tb_pipeline_mem.sv
// Self-checking bench for pipeline_mem: randomized instruction stream against
// an in-order transaction model, plus directed literal checks.
module tb_pipeline_mem;

    localparam int unsigned Depth = 256;
    localparam logic [31:0] TBase = 32'h4000_0000;
`ifdef MEM_TIMER_EN
    localparam bit TimerEn = 1'b1;
`else
    localparam bit TimerEn = 1'b0;
`endif

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] pc4;
        logic        mr;
        logic        mw;
        logic        rw;
        logic [1:0]  m2r;
        logic [4:0]  rd;
    } instr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipeline_mem_if bus ();

    pipeline_mem #(
        .RAM_DEPTH (Depth),
        .TIMER_BASE(TBase)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- model state ----------------
    logic [31:0] m_ram [Depth];
    logic [31:0] m_th, m_tl;
    logic [2:0]  m_tcon;
    instr_t      m_mem;    // instruction now in the MEM stage
    logic [31:0] e_wb;
    logic [4:0]  e_wb_rd;
    logic        e_wb_rw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if ((a >> 2) < Depth) return m_ram[a >> 2];
        if (TimerEn && a[31:4] == TBase[31:4]) begin
            case (a[3:2])
                2'd0:    return m_th;
                2'd1:    return m_tl;
                2'd2:    return {29'b0, m_tcon};
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    // Model: each edge retires the MEM instruction, ticks the timer, then
    // applies that instruction's store, then accepts the next instruction.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_mem = '{alu: 0, sdata: 0, pc4: 0, mr: 0, mw: 0, rw: 0, m2r: 0, rd: 0};
                e_wb = 0; e_wb_rd = 0; e_wb_rw = 0;
                m_th = 0; m_tl = 0; m_tcon = 0;
            end else begin
                case (m_mem.m2r)
                    2'd0:    e_wb = m_mem.alu;
                    2'd1:    e_wb = m_read(m_mem.alu);
                    2'd2:    e_wb = m_mem.pc4;
                    default: e_wb = 0;
                endcase
                e_wb_rd = m_mem.rd;
                e_wb_rw = m_mem.rw;
                if (TimerEn && m_tcon[0]) begin
                    if (m_tl == 32'hFFFF_FFFF) begin
                        m_tl = m_th;
                        if (m_tcon[1]) m_tcon[2] = 1'b1;
                    end else begin
                        m_tl = m_tl + 1;
                    end
                end
                if (m_mem.mw) begin
                    if ((m_mem.alu >> 2) < Depth) m_ram[m_mem.alu >> 2] = m_mem.sdata;
                    else if (TimerEn && m_mem.alu[31:4] == TBase[31:4]) begin
                        case (m_mem.alu[3:2])
                            2'd0:    m_th = m_mem.sdata;
                            2'd1:    m_tl = m_mem.sdata;
                            2'd2:    m_tcon = m_mem.sdata[2:0];
                            default: ;
                        endcase
                    end
                end
                m_mem.alu   = bus.EX_ALUOut;
                m_mem.sdata = bus.EX_StoreData;
                m_mem.pc4   = bus.EX_PC4;
                m_mem.mr    = bus.EX_MemRead & ~bus.EX_Flush;
                m_mem.mw    = bus.EX_MemWrite & ~bus.EX_Flush;
                m_mem.rw    = bus.EX_RegWrite & ~bus.EX_Flush;
                m_mem.m2r   = bus.EX_MemToReg;
                m_mem.rd    = bus.EX_Rd;
            end
        end
    end

    // Compare every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("exmem_data", bus.EXMEMdata, m_mem.alu);
            check("mem_rd", {27'b0, bus.MEM_Rd}, {27'b0, m_mem.rd});
            check("mem_regwrite", {31'b0, bus.MEM_RegWrite}, {31'b0, m_mem.rw});
            check("memwb_data", bus.MEMWBdata, e_wb);
            check("wb_rd", {27'b0, bus.WB_Rd}, {27'b0, e_wb_rd});
            check("wb_regwrite", {31'b0, bus.WB_RegWrite}, {31'b0, e_wb_rw});
            check("irq", {31'b0, bus.IRQ}, {31'b0, m_tcon[2]});
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] sdata,
                                  input logic [31:0] pc4, input logic mr, input logic mw,
                                  input logic rw, input logic [1:0] m2r, input logic [4:0] rd);
        instr_t i;
        i.alu = alu; i.sdata = sdata; i.pc4 = pc4;
        i.mr = mr; i.mw = mw; i.rw = rw; i.m2r = m2r; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(0, 0, 0, 0, 0, 0, 2'd0, 0);
    endfunction

    function automatic instr_t sw(input logic [31:0] a, input logic [31:0] d);
        return mk(a, d, 0, 0, 1, 0, 2'd0, 0);
    endfunction

    function automatic instr_t lw(input logic [31:0] a, input logic [4:0] rd);
        return mk(a, 0, 0, 1, 0, 1, 2'd1, rd);
    endfunction

    task automatic issue(input instr_t i, input logic flush);
        @(negedge clk);
        bus.EX_ALUOut    = i.alu;
        bus.EX_StoreData = i.sdata;
        bus.EX_PC4       = i.pc4;
        bus.EX_MemRead   = i.mr;
        bus.EX_MemWrite  = i.mw;
        bus.EX_RegWrite  = i.rw;
        bus.EX_MemToReg  = i.m2r;
        bus.EX_Rd        = i.rd;
        bus.EX_Flush     = flush;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_data();
        if ($urandom_range(0, 1) == 0) return $urandom;
        return 32'hFFFF_FFF0 | ($urandom & 32'hF);
    endfunction

    function automatic instr_t rnd_instr();
        int          kind;
        int          pick;
        logic [31:0] a;
        logic [1:0]  m2r;
        kind = $urandom_range(0, 6);
        case (kind)
            0, 1: begin
                pick = $urandom_range(0, 2);
                m2r = (pick == 0) ? 2'd0 : ((pick == 1) ? 2'd2 : 2'd3);
                return mk($urandom, $urandom, $urandom, 0, 0, 1'($urandom), m2r, 5'($urandom));
            end
            2: return lw((32'($urandom_range(0, 15)) << 2) | ($urandom & 3), 5'($urandom));
            3: return sw((32'($urandom_range(0, 15)) << 2) | ($urandom & 3), $urandom);
            4: begin
                a = 32'h8000_0000 | $urandom;
                if ($urandom_range(0, 1) == 0) return lw(a, 5'($urandom));
                return sw(a, $urandom);
            end
            5: begin
                a = TBase | (32'($urandom_range(0, 3)) << 2);
                if ($urandom_range(0, 1) == 0) return lw(a, 5'($urandom));
                return sw(a, rnd_data());
            end
            default: return mk($urandom, 0, $urandom, 0, 0, 1, 2'd2, 5'd31);
        endcase
    endfunction

    task automatic rnd_run(input int n);
        for (int k = 0; k < n; k++) begin
            issue(rnd_instr(), ($urandom_range(0, 7) == 0));
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.EX_Flush = 0; bus.EX_ALUOut = 0; bus.EX_StoreData = 0; bus.EX_PC4 = 0;
        bus.EX_MemRead = 0; bus.EX_MemWrite = 0; bus.EX_RegWrite = 0;
        bus.EX_MemToReg = 0; bus.EX_Rd = 0;
        #1 reset = 1'b1;
        #2;
        check("rst_exmem", bus.EXMEMdata, 32'h0);
        check("rst_memwb", bus.MEMWBdata, 32'h0);
        check("rst_irq", {31'b0, bus.IRQ}, 32'h0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Preload words 0..15 so every RAM load has defined data
        for (int i = 0; i < 16; i++) issue(sw(32'(i) << 2, 32'hA5A5_0000 + 32'(i)), 1'b0);

        // Store then dependent load of the same word
        issue(sw(32'h10, 32'hDEAD_BEEF), 1'b0);
        issue(lw(32'h10, 5'd5), 1'b0);
        issue(nop(), 1'b0);
        check("lw_after_sw", bus.MEMWBdata, 32'hDEAD_BEEF);
        check("lw_after_sw_rw", {31'b0, bus.WB_RegWrite}, 32'h1);
        check("lw_after_sw_rd", {27'b0, bus.WB_Rd}, 32'd5);

        // Beyond RAM: load reads 0, store must not alias word 0
        issue(lw(32'h400, 5'd6), 1'b0);
        issue(sw(32'h400, 32'h1234_5678), 1'b0);
        check("oob_load", bus.MEMWBdata, 32'h0);
        issue(lw(32'h0, 5'd7), 1'b0);
        issue(nop(), 1'b0);
        check("oob_store_no_alias", bus.MEMWBdata, 32'hA5A5_0000);

        // Flushed store: bubble, no write
        issue(mk(32'h14, 32'hBAD0_0000, 0, 0, 1, 1, 2'd0, 5'd9), 1'b1);
        check("flush_regwrite", {31'b0, bus.MEM_RegWrite}, 32'h0);
        issue(lw(32'h14, 5'd3), 1'b0);
        issue(nop(), 1'b0);
        check("flush_no_write", bus.MEMWBdata, 32'hA5A5_0005);

        // jal: PC+4 written back, ALU result forwarded one edge earlier
        issue(mk(32'h0000_1234, 0, 32'h0040_0008, 0, 0, 1, 2'd2, 5'd31), 1'b0);
        check("jal_exmem", bus.EXMEMdata, 32'h0000_1234);
        issue(nop(), 1'b0);
        check("jal_memwb", bus.MEMWBdata, 32'h0040_0008);

`ifdef MEM_TIMER_EN
        issue(sw(TBase, 32'hFFFF_FFF0), 1'b0);
        issue(sw(TBase + 4, 32'hFFFF_FFFE), 1'b0);
        issue(sw(TBase + 8, 32'h3), 1'b0);
        issue(lw(TBase + 4, 5'd1), 1'b0);
        check("tmr_irq_low", {31'b0, bus.IRQ}, 32'h0);
        issue(lw(TBase + 4, 5'd2), 1'b0);
        check("tmr_tl0", bus.MEMWBdata, 32'hFFFF_FFFE);
        issue(lw(TBase + 4, 5'd3), 1'b0);
        check("tmr_tl1", bus.MEMWBdata, 32'hFFFF_FFFF);
        check("tmr_irq_set", {31'b0, bus.IRQ}, 32'h1);
        issue(nop(), 1'b0);
        check("tmr_tl2", bus.MEMWBdata, 32'hFFFF_FFF0);
        issue(sw(TBase + 8, 32'h3), 1'b0);
        check("tmr_irq_hold", {31'b0, bus.IRQ}, 32'h1);
        issue(nop(), 1'b0);
        check("tmr_irq_clr", {31'b0, bus.IRQ}, 32'h0);
`endif

        rnd_run(400);

        // Reset in the middle of a cycle clears outputs at once
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_exmem", bus.EXMEMdata, 32'h0);
        check("mid_rst_mem_rd", {27'b0, bus.MEM_Rd}, 32'h0);
        check("mid_rst_mem_rw", {31'b0, bus.MEM_RegWrite}, 32'h0);
        check("mid_rst_memwb", bus.MEMWBdata, 32'h0);
        check("mid_rst_wb_rd", {27'b0, bus.WB_Rd}, 32'h0);
        check("mid_rst_wb_rw", {31'b0, bus.WB_RegWrite}, 32'h0);
        check("mid_rst_irq", {31'b0, bus.IRQ}, 32'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        issue(lw(TBase + 4, 5'd4), 1'b0);
        issue(nop(), 1'b0);
        check("post_rst_irq", {31'b0, bus.IRQ}, 32'h0);
        check("post_rst_tl", bus.MEMWBdata, 32'h0);

        rnd_run(200);
        issue(nop(), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
